bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared system bus.
- Sits between two bus masters (for example button-event masters) and the single bus interface.
- Grants the bus to one master at a time using round-robin priority.
- Muxes the granted master's request onto the bus, routes trans_done back only to that master, and aborts transactions that hang past a timeout.

Parameters:
- SLAVE_LEN, 2, width of slave_select.
- ADDR_LEN, 12, width of address.
- DATA_LEN, 8, width of data buses.
- TIMEOUT, 255, max cycles a grant may last without trans_done (>=2); counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m1_instruction  in  2  master 1 request: 2'b10 write, 2'b11 read, 2'b0x idle
- m1_slave_select  in  SLAVE_LEN  master 1 target slave
- m1_address  in  ADDR_LEN  master 1 address
- m1_data_out  in  DATA_LEN  master 1 write data
- m1_trans_done  out  1  completion pulse to master 1
- m1_timeout  out  1  abort flag, valid with m1_trans_done
- m2_*  (same six signals as m1_*, for master 2)
- m_data_in  out  DATA_LEN  read data broadcast to both masters (= bus_data_in)
- bus_instruction  out  2  to bus
- bus_slave_select  out  SLAVE_LEN  to bus
- bus_address  out  ADDR_LEN  to bus
- bus_data_out  out  DATA_LEN  to bus
- bus_data_in  in  DATA_LEN  read data from bus
- trans_done  in  1  bus completion pulse
- grant  out  2  one-hot grant: bit0 = M1, bit1 = M2
- bus_busy  out  1  high in any grant state

Behaviour:
- Request definition: reqN = mN_instruction[1].
- States: IDLE, GRANT_M1, GRANT_M2. State register, last_grant bit and timeout counter are all registered.
- Reset (sync):
  - state = IDLE, last_grant = M2 (so M1 wins first contention), counter = 0.
  - grant = 0, bus_busy = 0, all bus_* outputs = 0, mN_trans_done = 0, mN_timeout = 0.
- IDLE:
  - Only req1: go to GRANT_M1 next cycle.
  - Only req2: go to GRANT_M2 next cycle.
  - Both: grant the master that is not last_grant.
  - Neither: stay in IDLE.
  - Entering a grant state clears the counter and sets last_grant.
- GRANT_Mx, bus outputs: combinational copy of master x's instruction, slave_select, address and data_out. In IDLE all bus_* = 0.
- GRANT_Mx, completion: when trans_done = 1, mx_trans_done = 1 in the same cycle (combinational, gated by the grant), then return to IDLE.
  - The other master's trans_done is never asserted.
- GRANT_Mx, timeout: counter increments each cycle while trans_done = 0.
  - When the counter reaches TIMEOUT-1 with trans_done = 0: mx_trans_done = 1 and mx_timeout = 1 that cycle, bus_instruction forced to 2'b00, then return to IDLE.
  - If trans_done and the timeout point coincide, it is treated as normal completion with mx_timeout = 0.
- Latency:
  - Request to bus drive: 1 cycle.
  - trans_done to IDLE: 1 cycle.
  - Back-to-back grants to alternating masters: minimum 1 IDLE cycle between them.
- A master dropping its request mid-grant is ignored; the arbiter holds the grant until trans_done or timeout. The bus then sees instruction 00, and the timeout path recovers.
- trans_done while in IDLE is ignored and produces no pulse.
- Reset mid-transaction: on the next edge return to IDLE and zero all outputs. No trans_done pulse is produced.
- grant is always one-hot or zero; bus_busy = |grant.
- m_data_in = bus_data_in at all times; masters sample it on their trans_done.

Test Plan:
- Reset, then M1 writes (inst 10, slave 1, addr 186, data 77):
  - bus_instruction = 10, bus_address = 186, bus_data_out = 77 from the cycle after request.
  - trans_done at cycle 5 gives m1_trans_done = 1 at cycle 5; grant = 0 at cycle 6.
  - m2_trans_done stays 0 throughout.
- Both masters request on the same cycle after reset:
  - M1 is granted first.
  - After its completion, M2 is granted with exactly 1 IDLE cycle between grants.
  - A repeated simultaneous request then grants M1 again (round-robin).
- M2 reads (inst 11, addr 186) with bus_data_in = 85 at trans_done:
  - m_data_in = 85 on m2_trans_done; m2_timeout = 0.
- TIMEOUT = 8, M1 requests and trans_done never arrives:
  - m1_trans_done = 1 and m1_timeout = 1 on the 8th grant cycle, bus_instruction = 00 that cycle.
  - Next cycle is IDLE.
- trans_done arrives on the exact timeout cycle: m1_trans_done = 1 and m1_timeout = 0.
- Reset asserted during GRANT_M2:
  - Next cycle grant = 0 and all bus_* = 0; no mN_trans_done pulse.
  - A later trans_done while IDLE produces no pulse.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter: muxes the granted master onto the shared bus,
// returns completion only to that master and aborts grants that exceed TIMEOUT cycles.
module bus_arbiter #(
  parameter int SLAVE_LEN = 2,
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           m1_instruction,
  input  logic [SLAVE_LEN-1:0] m1_slave_select,
  input  logic [ADDR_LEN-1:0]  m1_address,
  input  logic [DATA_LEN-1:0]  m1_data_out,
  output logic                 m1_trans_done,
  output logic                 m1_timeout,
  input  logic [1:0]           m2_instruction,
  input  logic [SLAVE_LEN-1:0] m2_slave_select,
  input  logic [ADDR_LEN-1:0]  m2_address,
  input  logic [DATA_LEN-1:0]  m2_data_out,
  output logic                 m2_trans_done,
  output logic                 m2_timeout,
  output logic [DATA_LEN-1:0]  m_data_in,
  output logic [1:0]           bus_instruction,
  output logic [SLAVE_LEN-1:0] bus_slave_select,
  output logic [ADDR_LEN-1:0]  bus_address,
  output logic [DATA_LEN-1:0]  bus_data_out,
  input  logic [DATA_LEN-1:0]  bus_data_in,
  input  logic                 trans_done,
  output logic [1:0]           grant,
  output logic                 bus_busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M1 = 2'd1,
    GRANT_M2 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;  // 0 = M1 was last, 1 = M2 was last
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req1, req2;
  logic             done_ok;

  assign req1      = m1_instruction[1];
  assign req2      = m2_instruction[1];
  assign m_data_in = bus_data_in;
  assign bus_busy  = |grant;
  // A completion seen in the same cycle reset is asserted must not reach a master.
  assign done_ok   = trans_done && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    cnt_d            = cnt_q;
    grant            = 2'b00;
    bus_instruction  = 2'b00;
    bus_slave_select = '0;
    bus_address      = '0;
    bus_data_out     = '0;
    m1_trans_done    = 1'b0;
    m1_timeout       = 1'b0;
    m2_trans_done    = 1'b0;
    m2_timeout       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On contention the master that did not hold the bus last wins.
        if (req1 && (!req2 || last_grant_q)) begin
          state_d      = GRANT_M1;
          last_grant_d = 1'b0;
          cnt_d        = '0;
        end else if (req2) begin
          state_d      = GRANT_M2;
          last_grant_d = 1'b1;
          cnt_d        = '0;
        end
      end

      GRANT_M1: begin
        grant            = 2'b01;
        bus_instruction  = m1_instruction;
        bus_slave_select = m1_slave_select;
        bus_address      = m1_address;
        bus_data_out     = m1_data_out;
        if (done_ok) begin
          m1_trans_done = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          m1_trans_done   = !reset;
          m1_timeout      = !reset;
          bus_instruction = 2'b00;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GRANT_M2: begin
        grant            = 2'b10;
        bus_instruction  = m2_instruction;
        bus_slave_select = m2_slave_select;
        bus_address      = m2_address;
        bus_data_out     = m2_data_out;
        if (done_ok) begin
          m2_trans_done = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          m2_trans_done   = !reset;
          m2_timeout      = !reset;
          bus_instruction = 2'b00;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with TIMEOUT = 8: single grants, round-robin contention,
// read data return, timeout abort, timeout/completion coincidence and mid-grant reset.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m1_instruction, m2_instruction;
  logic [1:0]  m1_slave_select, m2_slave_select;
  logic [11:0] m1_address, m2_address;
  logic [7:0]  m1_data_out, m2_data_out;
  logic        m1_trans_done, m1_timeout, m2_trans_done, m2_timeout;
  logic [7:0]  m_data_in;
  logic [1:0]  bus_instruction;
  logic [1:0]  bus_slave_select;
  logic [11:0] bus_address;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in;
  logic        trans_done;
  logic [1:0]  grant;
  logic        bus_busy;

  int vectors = 0;
  int errors  = 0;

  bus_arbiter #(
    .SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .m1_instruction(m1_instruction), .m1_slave_select(m1_slave_select),
    .m1_address(m1_address), .m1_data_out(m1_data_out),
    .m1_trans_done(m1_trans_done), .m1_timeout(m1_timeout),
    .m2_instruction(m2_instruction), .m2_slave_select(m2_slave_select),
    .m2_address(m2_address), .m2_data_out(m2_data_out),
    .m2_trans_done(m2_trans_done), .m2_timeout(m2_timeout),
    .m_data_in(m_data_in),
    .bus_instruction(bus_instruction), .bus_slave_select(bus_slave_select),
    .bus_address(bus_address), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .trans_done(trans_done),
    .grant(grant), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge so inputs change away from it.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] i1, input logic [11:0] a1, input logic [7:0] d1,
                               input logic [1:0] i2, input logic [11:0] a2, input logic [7:0] d2,
                               input logic td);
    m1_instruction = i1; m1_address = a1; m1_data_out = d1;
    m2_instruction = i2; m2_address = a2; m2_data_out = d2;
    trans_done     = td;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " grant"}, 32'(grant), 32'd0);
    checkOutput({tag, " busy"}, 32'(bus_busy), 32'd0);
    checkOutput({tag, " bus_inst"}, 32'(bus_instruction), 32'd0);
    checkOutput({tag, " bus_addr"}, 32'(bus_address), 32'd0);
    checkOutput({tag, " bus_data"}, 32'(bus_data_out), 32'd0);
    checkOutput({tag, " bus_slave"}, 32'(bus_slave_select), 32'd0);
    checkOutput({tag, " m1_done"}, 32'(m1_trans_done), 32'd0);
    checkOutput({tag, " m2_done"}, 32'(m2_trans_done), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    m1_slave_select = 2'd1;
    m2_slave_select = 2'd2;
    bus_data_in = 8'h00;
    applyStimulus(2'b00, 12'd0, 8'd0, 2'b00, 12'd0, 8'd0, 1'b0);
    nextCycle();
    nextCycle();
    checkIdleOutputs("reset");
    reset = 1'b0;

    // M1 write: slave 1, addr 186, data 77
    applyStimulus(2'b10, 12'd186, 8'd77, 2'b00, 12'd0, 8'd0, 1'b0);
    checkOutput("w1 req cycle grant", 32'(grant), 32'd0);
    nextCycle();
    checkOutput("w1 grant", 32'(grant), 32'b01);
    checkOutput("w1 busy", 32'(bus_busy), 32'd1);
    checkOutput("w1 bus_inst", 32'(bus_instruction), 32'b10);
    checkOutput("w1 bus_addr", 32'(bus_address), 32'd186);
    checkOutput("w1 bus_data", 32'(bus_data_out), 32'd77);
    checkOutput("w1 bus_slave", 32'(bus_slave_select), 32'd1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("w1 wait m1_done", 32'(m1_trans_done), 32'd0);
      checkOutput("w1 wait grant", 32'(grant), 32'b01);
    end
    applyStimulus(2'b10, 12'd186, 8'd77, 2'b00, 12'd0, 8'd0, 1'b1);
    checkOutput("w1 m1_done", 32'(m1_trans_done), 32'd1);
    checkOutput("w1 m1_timeout", 32'(m1_timeout), 32'd0);
    checkOutput("w1 m2_done", 32'(m2_trans_done), 32'd0);
    nextCycle();
    applyStimulus(2'b00, 12'd0, 8'd0, 2'b00, 12'd0, 8'd0, 1'b0);
    checkIdleOutputs("w1 after");

    // Fresh reset so M1 wins the first contention
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    applyStimulus(2'b10, 12'h010, 8'h11, 2'b11, 12'd186, 8'h22, 1'b0);
    nextCycle();
    checkOutput("rr first grant", 32'(grant), 32'b01);
    checkOutput("rr first addr", 32'(bus_address), 32'h010);
    applyStimulus(2'b10, 12'h010, 8'h11, 2'b11, 12'd186, 8'h22, 1'b1);
    checkOutput("rr m1_done", 32'(m1_trans_done), 32'd1);
    checkOutput("rr m2_done idle", 32'(m2_trans_done), 32'd0);
    nextCycle();
    applyStimulus(2'b00, 12'd0, 8'd0, 2'b11, 12'd186, 8'h22, 1'b0);
    checkOutput("rr gap grant", 32'(grant), 32'd0);
    checkOutput("rr gap bus_inst", 32'(bus_instruction), 32'd0);
    nextCycle();
    checkOutput("rr second grant", 32'(grant), 32'b10);
    checkOutput("m2 read bus_inst", 32'(bus_instruction), 32'b11);
    checkOutput("m2 read bus_addr", 32'(bus_address), 32'd186);
    checkOutput("m2 read bus_slave", 32'(bus_slave_select), 32'd2);
    bus_data_in = 8'd85;
    applyStimulus(2'b00, 12'd0, 8'd0, 2'b11, 12'd186, 8'h22, 1'b1);
    checkOutput("m2 read m2_done", 32'(m2_trans_done), 32'd1);
    checkOutput("m2 read m_data_in", 32'(m_data_in), 32'd85);
    checkOutput("m2 read m2_timeout", 32'(m2_timeout), 32'd0);
    checkOutput("m2 read m1_done", 32'(m1_trans_done), 32'd0);
    nextCycle();
    applyStimulus(2'b10, 12'h030, 8'h33, 2'b11, 12'h040, 8'h44, 1'b0);
    checkOutput("rr gap2 grant", 32'(grant), 32'd0);
    nextCycle();
    checkOutput("rr third grant", 32'(grant), 32'b01);
    checkOutput("rr third addr", 32'(bus_address), 32'h030);
    applyStimulus(2'b10, 12'h030, 8'h33, 2'b11, 12'h040, 8'h44, 1'b1);
    checkOutput("rr third m1_done", 32'(m1_trans_done), 32'd1);
    nextCycle();
    applyStimulus(2'b00, 12'd0, 8'd0, 2'b00, 12'd0, 8'd0, 1'b0);
    checkOutput("rr end grant", 32'(grant), 32'd0);

    // Timeout: M1 granted, no trans_done for 8 grant cycles
    applyStimulus(2'b10, 12'h055, 8'h66, 2'b00, 12'd0, 8'd0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      nextCycle();
      checkOutput("to wait grant", 32'(grant), 32'b01);
      checkOutput("to wait m1_done", 32'(m1_trans_done), 32'd0);
      checkOutput("to wait bus_inst", 32'(bus_instruction), 32'b10);
    end
    nextCycle();
    checkOutput("to m1_done", 32'(m1_trans_done), 32'd1);
    checkOutput("to m1_timeout", 32'(m1_timeout), 32'd1);
    checkOutput("to bus_inst", 32'(bus_instruction), 32'b00);
    checkOutput("to m2_done", 32'(m2_trans_done), 32'd0);
    nextCycle();
    applyStimulus(2'b00, 12'd0, 8'd0, 2'b00, 12'd0, 8'd0, 1'b0);
    checkOutput("to next grant", 32'(grant), 32'd0);

    // trans_done on the exact timeout cycle is a normal completion
    applyStimulus(2'b10, 12'h077, 8'h88, 2'b00, 12'd0, 8'd0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      nextCycle();
      checkOutput("co wait m1_done", 32'(m1_trans_done), 32'd0);
    end
    nextCycle();
    applyStimulus(2'b10, 12'h077, 8'h88, 2'b00, 12'd0, 8'd0, 1'b1);
    checkOutput("co m1_done", 32'(m1_trans_done), 32'd1);
    checkOutput("co m1_timeout", 32'(m1_timeout), 32'd0);
    checkOutput("co bus_inst", 32'(bus_instruction), 32'b10);
    nextCycle();
    applyStimulus(2'b00, 12'd0, 8'd0, 2'b00, 12'd0, 8'd0, 1'b0);
    checkOutput("co next grant", 32'(grant), 32'd0);

    // Reset asserted while M2 holds the bus
    applyStimulus(2'b00, 12'd0, 8'd0, 2'b10, 12'h0AA, 8'hBB, 1'b0);
    nextCycle();
    checkOutput("rst grant m2", 32'(grant), 32'b10);
    checkOutput("rst bus_addr m2", 32'(bus_address), 32'h0AA);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    applyStimulus(2'b00, 12'd0, 8'd0, 2'b00, 12'd0, 8'd0, 1'b0);
    checkIdleOutputs("rst after");
    nextCycle();
    applyStimulus(2'b00, 12'd0, 8'd0, 2'b00, 12'd0, 8'd0, 1'b1);
    checkIdleOutputs("idle trans_done");
    nextCycle();
    applyStimulus(2'b00, 12'd0, 8'd0, 2'b00, 12'd0, 8'd0, 1'b0);
    checkOutput("final grant", 32'(grant), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
